// File: rtl/regfile_write_arbiter.sv
// Register-file write-port arbiter.
// Three requesters share the single regfile write port:
//   - writeback (wb) has fixed highest priority,
//   - multdiv (md) and IO (io) share the remaining slots round-robin.
// A zero-sweep (r1..r31 <- 0) can be started with clear_start; while it
// runs the arbiter grants nothing and the port is driven by the sweep.
// Grants are combinational; the write itself is registered and appears on
// ctrl_writeEn/ctrl_writeReg/data_writeReg for the cycle after the grant.
module regfile_write_arbiter (
    input  logic        clock,
    input  logic        ctrl_reset,
    input  logic        req_wb,
    input  logic [4:0]  wb_reg,
    input  logic [31:0] wb_data,
    input  logic        req_md,
    input  logic [4:0]  md_reg,
    input  logic [31:0] md_data,
    input  logic        req_io,
    input  logic [4:0]  io_reg,
    input  logic [31:0] io_data,
    input  logic        clear_start,
    output logic        gnt_wb,
    output logic        gnt_md,
    output logic        gnt_io,
    output logic        ctrl_writeEn,
    output logic [4:0]  ctrl_writeReg,
    output logic [31:0] data_writeReg,
    output logic        busy
);

    typedef enum logic {
        IDLE  = 1'b0,
        SWEEP = 1'b1
    } state_t;

    localparam logic [4:0] LAST_REG = 5'd31;

    state_t      state, state_next;
    logic [4:0]  count, count_next;      // next register the sweep will clear
    logic        rr, rr_next;            // 0: md favoured, 1: io favoured
    logic        granted;
    logic        we_next;
    logic [4:0]  reg_next;
    logic [31:0] data_next;

    // Next-state, grant and write-port selection.
    always_comb begin
        // NOTE: every output of this block gets a default first so that no
        // path leaves a variable unassigned, which would infer a latch.
        state_next = state;
        count_next = count;
        rr_next    = rr;
        gnt_wb     = 1'b0;
        gnt_md     = 1'b0;
        gnt_io     = 1'b0;
        granted    = 1'b0;
        we_next    = 1'b0;
        reg_next   = ctrl_writeReg;
        data_next  = data_writeReg;

        case (state)
            IDLE: begin
                if (clear_start) begin
                    // Accepting a sweep takes the whole cycle: no grant.
                    state_next = SWEEP;
                    count_next = 5'd1;
                end else if (req_wb) begin
                    gnt_wb    = 1'b1;
                    granted   = 1'b1;
                    reg_next  = wb_reg;
                    data_next = wb_data;
                end else if (req_md && (!req_io || !rr)) begin
                    gnt_md    = 1'b1;
                    granted   = 1'b1;
                    rr_next   = 1'b1;
                    reg_next  = md_reg;
                    data_next = md_data;
                end else if (req_io) begin
                    gnt_io    = 1'b1;
                    granted   = 1'b1;
                    rr_next   = 1'b0;
                    reg_next  = io_reg;
                    data_next = io_data;
                end
                // r0 is hard-wired zero: the request is consumed but no
                // write is issued.
                we_next = granted && (reg_next != 5'd0);
            end
            SWEEP: begin
                we_next   = 1'b1;
                reg_next  = count;
                data_next = 32'd0;
                if (count == LAST_REG) begin
                    state_next = IDLE;
                    count_next = 5'd1;
                end else begin
                    count_next = count + 5'd1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // Nothing may be granted while reset is held.
        if (ctrl_reset) begin
            gnt_wb = 1'b0;
            gnt_md = 1'b0;
            gnt_io = 1'b0;
        end
    end

    // State, round-robin pointer and registered write port.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (ctrl_reset) begin
            state         <= IDLE;
            count         <= 5'd1;
            rr            <= 1'b0;
            ctrl_writeEn  <= 1'b0;
            ctrl_writeReg <= 5'd0;
            data_writeReg <= 32'd0;
        end else begin
            state         <= state_next;
            count         <= count_next;
            rr            <= rr_next;
            ctrl_writeEn  <= we_next;
            ctrl_writeReg <= reg_next;
            data_writeReg <= data_next;
        end
    end

    assign busy = (state == SWEEP);

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Directed and randomised bench for regfile_write_arbiter. A small regfile
// is written from the DUT's write port and compared with a reference copy.
module tb_regfile_write_arbiter;

    logic        clock;
    logic        ctrl_reset;
    logic        req_wb, req_md, req_io;
    logic [4:0]  wb_reg, md_reg, io_reg;
    logic [31:0] wb_data, md_data, io_data;
    logic        clear_start;
    logic        gnt_wb, gnt_md, gnt_io;
    logic        ctrl_writeEn;
    logic [4:0]  ctrl_writeReg;
    logic [31:0] data_writeReg;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] rf       [0:31];
    logic [31:0] model_rf [0:31];

    regfile_write_arbiter dut (
        .clock         (clock),
        .ctrl_reset    (ctrl_reset),
        .req_wb        (req_wb),
        .wb_reg        (wb_reg),
        .wb_data       (wb_data),
        .req_md        (req_md),
        .md_reg        (md_reg),
        .md_data       (md_data),
        .req_io        (req_io),
        .io_reg        (io_reg),
        .io_data       (io_data),
        .clear_start   (clear_start),
        .gnt_wb        (gnt_wb),
        .gnt_md        (gnt_md),
        .gnt_io        (gnt_io),
        .ctrl_writeEn  (ctrl_writeEn),
        .ctrl_writeReg (ctrl_writeReg),
        .data_writeReg (data_writeReg),
        .busy          (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Regfile fed by the DUT write port.
    always @(posedge clock) begin
        if (ctrl_writeEn && ctrl_writeReg != 5'd0)
            rf[ctrl_writeReg] <= data_writeReg;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic clear_inputs();
        req_wb = 1'b0; wb_reg = 5'd0; wb_data = 32'd0;
        req_md = 1'b0; md_reg = 5'd0; md_data = 32'd0;
        req_io = 1'b0; io_reg = 5'd0; io_data = 32'd0;
        clear_start = 1'b0;
    endtask

    task automatic apply_reset();
        ctrl_reset = 1'b1;
        clear_inputs();
        tick();
        tick();
        ctrl_reset = 1'b0;
    endtask

    task automatic test_reset();
        ctrl_reset = 1'b1;
        clear_inputs();
        req_wb = 1'b1; req_md = 1'b1; req_io = 1'b1; wb_reg = 5'd3;
        #1;
        n_tests++;
        if ({gnt_wb, gnt_md, gnt_io} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_gnt: got %b expected 000", {gnt_wb, gnt_md, gnt_io});
        end
        tick();
        n_tests++;
        if ({ctrl_writeEn, ctrl_writeReg, data_writeReg, busy} !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got we=%b reg=%0d data=%h busy=%b expected all 0",
                     ctrl_writeEn, ctrl_writeReg, data_writeReg, busy);
        end
        tick();
        ctrl_reset = 1'b0;
        clear_inputs();
        tick();
    endtask

    task automatic test_wb_priority();
        req_wb = 1'b1; wb_reg = 5'd5; wb_data = 32'hFFFF_FFFF;
        req_md = 1'b1; md_reg = 5'd6; md_data = 32'h0000_1234;
        #1;
        n_tests++;
        if ({gnt_wb, gnt_md, gnt_io} !== 3'b100) begin
            n_fail++;
            $display("FAIL wb_prio_gnt: got %b expected 100", {gnt_wb, gnt_md, gnt_io});
        end
        tick();
        req_wb = 1'b0;
        n_tests++;
        if ({ctrl_writeEn, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd5, 32'hFFFF_FFFF}) begin
            n_fail++;
            $display("FAIL wb_prio_write: got we=%b reg=%0d data=%h expected 1/5/ffffffff",
                     ctrl_writeEn, ctrl_writeReg, data_writeReg);
        end
        #1;
        n_tests++;
        if ({gnt_wb, gnt_md, gnt_io} !== 3'b010) begin
            n_fail++;
            $display("FAIL wb_then_md_gnt: got %b expected 010", {gnt_wb, gnt_md, gnt_io});
        end
        tick();
        req_md = 1'b0;
        n_tests++;
        if ({ctrl_writeEn, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd6, 32'h0000_1234}) begin
            n_fail++;
            $display("FAIL md_write: got we=%b reg=%0d data=%h expected 1/6/00001234",
                     ctrl_writeEn, ctrl_writeReg, data_writeReg);
        end
        tick();
        n_tests++;
        if ({ctrl_writeEn, ctrl_writeReg, data_writeReg} !== {1'b0, 5'd6, 32'h0000_1234}) begin
            n_fail++;
            $display("FAIL idle_hold: got we=%b reg=%0d data=%h expected 0/6/00001234",
                     ctrl_writeEn, ctrl_writeReg, data_writeReg);
        end
    endtask

    task automatic test_round_robin();
        logic [2:0]  exp_g;
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;
        apply_reset();
        req_md = 1'b1; md_reg = 5'd7; md_data = 32'hAAAA_0007;
        req_io = 1'b1; io_reg = 5'd8; io_data = 32'hBBBB_0008;
        #1;
        for (int i = 0; i < 4; i++) begin
            exp_g    = (i % 2 == 0) ? 3'b010 : 3'b001;
            exp_reg  = (i % 2 == 0) ? 5'd7 : 5'd8;
            exp_data = (i % 2 == 0) ? 32'hAAAA_0007 : 32'hBBBB_0008;
            n_tests++;
            if ({gnt_wb, gnt_md, gnt_io} !== exp_g) begin
                n_fail++;
                $display("FAIL rr_gnt[%0d]: got %b expected %b", i, {gnt_wb, gnt_md, gnt_io}, exp_g);
            end
            tick();
            n_tests++;
            if ({ctrl_writeEn, ctrl_writeReg, data_writeReg} !== {1'b1, exp_reg, exp_data}) begin
                n_fail++;
                $display("FAIL rr_write[%0d]: got we=%b reg=%0d data=%h expected 1/%0d/%h",
                         i, ctrl_writeEn, ctrl_writeReg, data_writeReg, exp_reg, exp_data);
            end
        end
        clear_inputs();
        tick();
    endtask

    task automatic test_reg_zero();
        // rr is 0 (md favoured) here, so this also covers a lone io request.
        req_io = 1'b1; io_reg = 5'd0; io_data = 32'h0000_7897;
        #1;
        n_tests++;
        if ({gnt_wb, gnt_md, gnt_io} !== 3'b001) begin
            n_fail++;
            $display("FAIL reg0_gnt: got %b expected 001", {gnt_wb, gnt_md, gnt_io});
        end
        tick();
        req_io = 1'b0;
        n_tests++;
        if (ctrl_writeEn !== 1'b0) begin
            n_fail++;
            $display("FAIL reg0_we: got %b expected 0", ctrl_writeEn);
        end
        tick();
    endtask

    task automatic test_sweep();
        logic ok;
        // rr is 0 after the io grant above.
        clear_start = 1'b1;
        req_wb = 1'b1; wb_reg = 5'd9; wb_data = 32'h0000_DEAD;
        #1;
        n_tests++;
        if ({gnt_wb, gnt_md, gnt_io, busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL sweep_accept: got gnt=%b busy=%b expected 000/0",
                     {gnt_wb, gnt_md, gnt_io}, busy);
        end
        tick();
        // clear_start stays high for the first sweep cycle: it must be ignored.
        for (int k = 1; k <= 31; k++) begin
            if (k == 2) clear_start = 1'b0;
            #1;
            n_tests++;
            if ({busy, gnt_wb, gnt_md, gnt_io} !== 4'b1000) begin
                n_fail++;
                $display("FAIL sweep_busy[%0d]: got busy=%b gnt=%b expected 1/000",
                         k, busy, {gnt_wb, gnt_md, gnt_io});
            end
            tick();
            n_tests++;
            if ({ctrl_writeEn, ctrl_writeReg, data_writeReg} !== {1'b1, 5'(k), 32'd0}) begin
                n_fail++;
                $display("FAIL sweep_write[%0d]: got we=%b reg=%0d data=%h expected 1/%0d/0",
                         k, ctrl_writeEn, ctrl_writeReg, data_writeReg, k);
            end
        end
        n_tests++;
        if ({busy, gnt_wb, gnt_md, gnt_io} !== 4'b0100) begin
            n_fail++;
            $display("FAIL sweep_end: got busy=%b gnt=%b expected 0/100",
                     busy, {gnt_wb, gnt_md, gnt_io});
        end
        tick();
        req_wb = 1'b0;
        n_tests++;
        if ({ctrl_writeEn, ctrl_writeReg, data_writeReg} !== {1'b1, 5'd9, 32'h0000_DEAD}) begin
            n_fail++;
            $display("FAIL post_sweep_wb: got we=%b reg=%0d data=%h expected 1/9/0000dead",
                     ctrl_writeEn, ctrl_writeReg, data_writeReg);
        end
        ok = 1'b1;
        for (int r = 1; r < 32; r++)
            if (rf[r] !== 32'd0) ok = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL sweep_cleared: got nonzero register in r1..r31 expected all 0");
        end
        // rr must still favour md after the sweep.
        req_md = 1'b1; md_reg = 5'd12; req_io = 1'b1; io_reg = 5'd13;
        #1;
        n_tests++;
        if ({gnt_wb, gnt_md, gnt_io} !== 3'b010) begin
            n_fail++;
            $display("FAIL sweep_rr: got %b expected 010", {gnt_wb, gnt_md, gnt_io});
        end
        tick();
        clear_inputs();
        tick();
    endtask

    task automatic test_reset_mid_sweep();
        logic ok;
        // Fill r10..r31 with a known nonzero pattern.
        for (int r = 10; r < 32; r++) begin
            req_wb = 1'b1; wb_reg = 5'(r); wb_data = 32'hC0DE_0000 | 32'(r);
            tick();
        end
        clear_inputs();
        tick();
        tick();
        clear_start = 1'b1;
        tick();
        clear_start = 1'b0;
        // Now in the k=1 sweep cycle; advance to k=10.
        for (int k = 1; k < 10; k++) tick();
        ctrl_reset = 1'b1;
        req_md = 1'b1; md_reg = 5'd4;
        #1;
        n_tests++;
        if ({gnt_wb, gnt_md, gnt_io} !== 3'b000) begin
            n_fail++;
            $display("FAIL midsweep_reset_gnt: got %b expected 000", {gnt_wb, gnt_md, gnt_io});
        end
        tick();
        ctrl_reset = 1'b0;
        req_md = 1'b0;
        n_tests++;
        if ({ctrl_writeEn, busy, ctrl_writeReg, data_writeReg} !== 39'd0) begin
            n_fail++;
            $display("FAIL midsweep_reset_out: got we=%b busy=%b reg=%0d data=%h expected all 0",
                     ctrl_writeEn, busy, ctrl_writeReg, data_writeReg);
        end
        tick();
        tick();
        n_tests++;
        if ({ctrl_writeEn, busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL midsweep_idle: got we=%b busy=%b expected 0/0", ctrl_writeEn, busy);
        end
        ok = 1'b1;
        for (int r = 11; r < 32; r++)
            if (rf[r] !== (32'hC0DE_0000 | 32'(r))) ok = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL midsweep_upper: got r11..r31 modified expected c0de00xx pattern");
        end
        ok = 1'b1;
        for (int r = 1; r < 10; r++)
            if (rf[r] !== 32'd0) ok = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL midsweep_lower: got nonzero in r1..r9 expected 0");
        end
    endtask

    task automatic test_random();
        logic        p_wb, p_md, p_io, exp_rr, ok;
        logic [4:0]  r_wb, r_md, r_io;
        logic [31:0] d_wb, d_md, d_io;
        logic [2:0]  exp_g;
        int          issued, granted, multi;
        apply_reset();
        for (int r = 0; r < 32; r++) model_rf[r] = rf[r];
        p_wb = 1'b0; p_md = 1'b0; p_io = 1'b0; exp_rr = 1'b0;
        r_wb = 5'd0; r_md = 5'd0; r_io = 5'd0;
        d_wb = 32'd0; d_md = 32'd0; d_io = 32'd0;
        issued = 0; granted = 0; multi = 0;
        for (int c = 0; c < 10000; c++) begin
            if (!p_wb && $urandom_range(0, 3) == 0) begin
                p_wb = 1'b1; r_wb = 5'($urandom_range(0, 31)); d_wb = $urandom; issued++;
            end
            if (!p_md && $urandom_range(0, 1) == 1) begin
                p_md = 1'b1; r_md = 5'($urandom_range(0, 31)); d_md = $urandom; issued++;
            end
            if (!p_io && $urandom_range(0, 1) == 1) begin
                p_io = 1'b1; r_io = 5'($urandom_range(0, 31)); d_io = $urandom; issued++;
            end
            req_wb = p_wb; wb_reg = r_wb; wb_data = d_wb;
            req_md = p_md; md_reg = r_md; md_data = d_md;
            req_io = p_io; io_reg = r_io; io_data = d_io;
            #1;
            if (p_wb)                       exp_g = 3'b100;
            else if (p_md && (!p_io || !exp_rr)) exp_g = 3'b010;
            else if (p_io)                  exp_g = 3'b001;
            else                            exp_g = 3'b000;
            if ($countones({gnt_wb, gnt_md, gnt_io}) > 1) multi++;
            n_tests++;
            if ({gnt_wb, gnt_md, gnt_io} !== exp_g) begin
                n_fail++;
                $display("FAIL rand_gnt[%0d]: got %b expected %b", c, {gnt_wb, gnt_md, gnt_io}, exp_g);
            end
            case (exp_g)
                3'b100: begin
                    if (r_wb != 5'd0) model_rf[r_wb] = d_wb;
                    p_wb = 1'b0; granted++;
                end
                3'b010: begin
                    if (r_md != 5'd0) model_rf[r_md] = d_md;
                    p_md = 1'b0; exp_rr = 1'b1; granted++;
                end
                3'b001: begin
                    if (r_io != 5'd0) model_rf[r_io] = d_io;
                    p_io = 1'b0; exp_rr = 1'b0; granted++;
                end
                default: ;
            endcase
            tick();
        end
        clear_inputs();
        tick();
        tick();
        n_tests++;
        if (multi != 0) begin
            n_fail++;
            $display("FAIL rand_onehot: got %0d multi-grant cycles expected 0", multi);
        end
        n_tests++;
        if (issued != granted + int'(p_wb) + int'(p_md) + int'(p_io)) begin
            n_fail++;
            $display("FAIL rand_count: got %0d granted+pending expected %0d issued",
                     granted + int'(p_wb) + int'(p_md) + int'(p_io), issued);
        end
        ok = 1'b1;
        for (int r = 1; r < 32; r++)
            if (rf[r] !== model_rf[r]) ok = 1'b0;
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL rand_regfile: got regfile differing from model expected identical");
        end
    endtask

    initial begin
        test_reset();
        test_wb_priority();
        test_round_robin();
        test_reg_zero();
        test_sweep();
        test_reset_mid_sweep();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "timeout");
    end

endmodule
